uart_rx_fifo: RTL

//  UART receiver with byte FIFO; consumes the SoC serial output io_uart_txd (8N1, LSB first).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo_if.sv | 20 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready).
interface uart_rx_fifo_if;

    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the output holds the last popped word while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] hold;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a byte FIFO for a valid/ready consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int CLOCK_FREQ = 30000000,
    parameter  int BAUD_RATE  = 921600,
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx,
    uart_rx_fifo_if.master        bus,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [CW-1:0]         fifo_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_STOP  = 2'(STOP);

    logic             rx_meta;
    logic             rx_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             stop_tick;
    logic             push;
    logic             full;
    logic             empty;

    assign stop_tick      = (state == ST_STOP) && (baud_cnt == BIT_END);
    assign push           = stop_tick && rx_s;
    assign busy           = (state != ST_IDLE);
    assign bus.data_valid = !empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Start is re-checked at half a bit so short low glitches fall back to idle silently.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= stop_tick && !rx_s;
            overflow  <= push && full && !(bus.data_ready && !empty);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (shift),
        .pop    (bus.data_ready),
        .dout   (bus.data),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

endmodule
